branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined MIPS core. It is looked up combinationally with the IF-stage PC and returns a predicted direction and target. It is updated with the resolved outcome when a branch reaches MEM, and it raises a misprediction/redirect the pipeline uses to flush IF/ID/EX. It replaces static "predict not-taken, resolve in MEM" and supports bimodal or gshare indexing, plus saturating performance counters.

## Interface
Parameters:
- ENTRIES, 16, entries in both the PHT and the BTB; power of two, ≥2; INDEX_W = log2(ENTRIES)
- TAG_W, 8, BTB tag width, taken from PC[INDEX_W+TAG_W+1 : INDEX_W+2]
- CTR_W, 2, saturating-counter width, ≥1
- GHR_W, 0, global-history length; 0 = bimodal mode, 1..INDEX_W = gshare mode
- CNT_W, 16, performance-counter width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- if_pc_i  in  32  PC being fetched
- pred_taken_o  out  1  predicted taken (combinational)
- pred_target_o  out  32  predicted target; 0 when pred_hit_o=0
- pred_hit_o  out  1  BTB tag hit for if_pc_i
- pred_idx_o  out  INDEX_W  PHT index used; carried down the pipe
- upd_valid_i  in  1  a resolved branch is in MEM this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_idx_i  in  INDEX_W  pred_idx_o captured at that branch's fetch
- upd_taken_i  in  1  actual direction
- upd_target_i  in  32  actual taken target
- upd_pred_taken_i  in  1  direction predicted at fetch
- upd_pred_target_i  in  32  target predicted at fetch
- mispredict_o  out  1  flush request (combinational)
- redirect_pc_o  out  32  correct next PC when mispredict_o=1
- branch_cnt_o  out  CNT_W  resolved branches since reset
- mispredict_cnt_o  out  CNT_W  mispredictions since reset

## Operation
- State:
  - PHT: ENTRIES × CTR_W counters.
  - BTB: ENTRIES × {valid, tag, target}.
  - GHR: GHR_W bits, present only when GHR_W > 0.
  - Two perf counters.
- Lookup (combinational):
  - bidx = if_pc_i[INDEX_W+1:2].
  - pidx = bidx XOR {zero-pad, GHR} in gshare mode; pidx = bidx in bimodal mode.
  - pred_hit_o = valid[bidx] && tag[bidx] == PC tag field.
  - pred_taken_o = pred_hit_o && PHT[pidx][CTR_W-1].
  - pred_target_o = pred_hit_o ? target[bidx] : 0.
  - pred_idx_o = pidx.
- Misprediction (combinational):
  - mispredict_o = upd_valid_i && (upd_taken_i != upd_pred_taken_i || (upd_taken_i && upd_pred_target_i != upd_target_i)).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 4, valid whenever upd_valid_i.
- Update, on the clock edge when upd_valid_i=1:
  - PHT[upd_idx_i]: +1 if taken, −1 if not taken; saturates at 2^CTR_W−1 and at 0.
  - If taken, BTB[upd_pc_i[INDEX_W+1:2]] ← {1, tag(upd_pc_i), upd_target_i}. This overwrites any aliasing entry. Not-taken updates leave the BTB unchanged.
  - GHR ← {GHR[GHR_W-2:0], upd_taken_i}, which is non-speculative.
  - branch_cnt_o +1; mispredict_cnt_o +1 if mispredict_o. Both saturate at all-ones with no wrap.
- upd_valid_i=0: no state change. mispredict_o=0.

## Timing
- Reset values (rst_i=1 at an edge):
  - Every PHT counter = 2^(CTR_W−1)−1, i.e. weakly not-taken (01 for CTR_W=2).
  - All BTB valid bits = 0. GHR = 0. Both perf counters = 0.
  - Resulting outputs: pred_taken_o=0, pred_hit_o=0, pred_target_o=0. mispredict_o follows its inputs.
- Reset has priority over a simultaneous upd_valid_i: the update is dropped and not counted.
- Lookup and mispredict have zero-cycle latency. Update is visible to lookups from the cycle after the edge.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update (old) contents, with no bypass.
- Back-to-back updates every cycle are supported. Each one reads state already modified by the previous edge.
- The pipeline guarantees at most one update per cycle. Holding upd_valid_i for N cycles counts N updates.

## Test plan
- Reset, then if_pc_i=0x40 → pred_hit_o=0, pred_taken_o=0, pred_target_o=0, counters=0.
- Bimodal, CTR_W=2: PC 0x40 resolved taken to 0x80 twice (upd_pred_taken_i=0) → mispredict_o=1 and redirect 0x80 each time. Counter goes 01→10→11. Lookup 0x40 then gives hit, taken, target 0x80. mispredict_cnt_o=2, branch_cnt_o=2.
- Saturation: 3 further taken updates leave the counter at 11. Then 2 not-taken updates (predicted taken) → counter 01, pred_taken_o=0, redirect_pc_o=0x44.
- Aliasing, ENTRIES=16: taken 0x40→0x80, then taken 0x440→0x900 (same index, different tag) → lookup 0x40 misses, lookup 0x440 hits with target 0x900.
- Gshare, GHR_W=4: updates with outcomes T,T,N,T → GHR=1101. Lookup 0x40 gives pred_idx_o = 0x0 XOR 0xD = 0xD. Target mismatch alone (both taken, 0x80 vs 0x84) → mispredict_o=1.
- rst_i asserted with upd_valid_i=1 mid-stream → all state returns to reset values; the update is not counted. CNT_W=4: 20 updates → branch_cnt_o=15.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: PHT of saturating counters plus a tagged BTB,
// indexed bimodally or with gshare history, with saturating perf counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 0,
  parameter int CNT_W   = 16,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        if_pc_i,
  output logic               pred_taken_o,
  output logic [31:0]        pred_target_o,
  output logic               pred_hit_o,
  output logic [INDEX_W-1:0] pred_idx_o,
  input  logic               upd_valid_i,
  input  logic [31:0]        upd_pc_i,
  input  logic [INDEX_W-1:0] upd_idx_i,
  input  logic               upd_taken_i,
  input  logic [31:0]        upd_target_i,
  input  logic               upd_pred_taken_i,
  input  logic [31:0]        upd_pred_target_i,
  output logic               mispredict_o,
  output logic [31:0]        redirect_pc_o,
  output logic [CNT_W-1:0]   branch_cnt_o,
  output logic [CNT_W-1:0]   mispredict_cnt_o
);

  localparam int TAG_LO = INDEX_W + 2;
  localparam int TAG_HI = INDEX_W + TAG_W + 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CTR_W-1:0]   pht [ENTRIES];
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [INDEX_W-1:0] hist;
  logic [CNT_W-1:0]   branch_cnt;
  logic [CNT_W-1:0]   mispredict_cnt;

  logic [INDEX_W-1:0] lk_bidx;
  logic [INDEX_W-1:0] lk_pidx;
  logic [TAG_W-1:0]   lk_tag;
  logic [INDEX_W-1:0] upd_bidx;
  logic [TAG_W-1:0]   upd_tag;
  logic               dir_wrong;
  logic               tgt_wrong;
  logic               upd_en;
  logic               btb_wr;
  logic               unused_pc_bits;

  // Only the index and tag fields of the fetch PC matter.
  assign unused_pc_bits = ^if_pc_i;

  // Global history, zero-extended into the index space for the gshare XOR.
  generate
    if (GHR_W > 0) begin : g_gshare
      logic [GHR_W-1:0] ghr;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ghr <= '0;
        end else if (upd_valid_i) begin
          ghr <= GHR_W'({ghr, upd_taken_i});
        end
      end
      assign hist = INDEX_W'(ghr);
    end else begin : g_bimodal
      assign hist = '0;
    end
  endgenerate

  // Lookup: BTB indexed by PC bits only, PHT optionally hashed with history.
  assign lk_bidx       = if_pc_i[INDEX_W+1:2];
  assign lk_tag        = if_pc_i[TAG_HI:TAG_LO];
  assign lk_pidx       = lk_bidx ^ hist;
  assign pred_hit_o    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
  assign pred_taken_o  = pred_hit_o && pht[lk_pidx][CTR_W-1];
  assign pred_target_o = pred_hit_o ? btb_target[lk_bidx] : 32'd0;
  assign pred_idx_o    = lk_pidx;

  // Resolution in MEM.
  assign upd_bidx      = upd_pc_i[INDEX_W+1:2];
  assign upd_tag       = upd_pc_i[TAG_HI:TAG_LO];
  assign dir_wrong     = upd_taken_i != upd_pred_taken_i;
  assign tgt_wrong     = upd_taken_i && (upd_pred_target_i != upd_target_i);
  assign mispredict_o  = upd_valid_i && (dir_wrong || tgt_wrong);
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

  // Reset wins over a coincident update, so the update is simply lost.
  assign upd_en = upd_valid_i && !rst_i;
  assign btb_wr = upd_en && upd_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= CTR_INIT;
      end
    end else if (upd_valid_i) begin
      if (upd_taken_i && (pht[upd_idx_i] != CTR_MAX)) begin
        pht[upd_idx_i] <= pht[upd_idx_i] + CTR_W'(1);
      end else if (!upd_taken_i && (pht[upd_idx_i] != '0)) begin
        pht[upd_idx_i] <= pht[upd_idx_i] - CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btb_valid <= '0;
    end else if (btb_wr) begin
      btb_valid[upd_bidx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (btb_wr) begin
      btb_tag[upd_bidx]    <= upd_tag;
      btb_target[upd_bidx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd_en) begin
      if (branch_cnt != CNT_MAX) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict_o && (mispredict_cnt != CNT_MAX)) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

  assign branch_cnt_o     = branch_cnt;
  assign mispredict_cnt_o = mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal instance (4-bit perf counters) and a
// gshare instance (4-bit history) share stimulus, each with its own model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_idx_b;
  logic [3:0]  upd_idx_g;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        b_taken, b_hit, b_misp;
  logic [31:0] b_target, b_redirect;
  logic [3:0]  b_idx, b_bcnt, b_mcnt;
  logic        g_taken, g_hit, g_misp;
  logic [31:0] g_target, g_redirect;
  logic [3:0]  g_idx;
  logic [15:0] g_bcnt, g_mcnt;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
    .pred_taken_o(b_taken), .pred_target_o(b_target), .pred_hit_o(b_hit),
    .pred_idx_o(b_idx), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_idx_i(upd_idx_b), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
    .mispredict_o(b_misp), .redirect_pc_o(b_redirect),
    .branch_cnt_o(b_bcnt), .mispredict_cnt_o(b_mcnt)
  );

  branch_predictor #(.GHR_W(4)) dut_g (
    .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
    .pred_taken_o(g_taken), .pred_target_o(g_target), .pred_hit_o(g_hit),
    .pred_idx_o(g_idx), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_idx_i(upd_idx_g), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
    .mispredict_o(g_misp), .redirect_pc_o(g_redirect),
    .branch_cnt_o(g_bcnt), .mispredict_cnt_o(g_mcnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (index 0 = bimodal, 1 = gshare) ----------------
  int          pht_m [2][16];
  bit          bv_m  [2][16];
  int          tag_m [2][16];
  logic [31:0] tgt_m [2][16];
  int          ghr_m [2];
  int          bcnt_m[2];
  int          mcnt_m[2];

  function automatic int cnt_max(int m);
    return (m == 0) ? 15 : 65535;
  endfunction

  function automatic void m_reset();
    for (int m = 0; m < 2; m++) begin
      for (int e = 0; e < 16; e++) begin
        pht_m[m][e] = 1;
        bv_m[m][e]  = 0;
      end
      ghr_m[m] = 0; bcnt_m[m] = 0; mcnt_m[m] = 0;
    end
  endfunction

  function automatic int pc_slot(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int pc_tag(logic [31:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  function automatic int m_idx(int m, logic [31:0] pc);
    return (m == 1) ? (pc_slot(pc) ^ ghr_m[m]) : pc_slot(pc);
  endfunction

  function automatic bit m_hit(int m, logic [31:0] pc);
    return bv_m[m][pc_slot(pc)] && (tag_m[m][pc_slot(pc)] == pc_tag(pc));
  endfunction

  function automatic bit m_taken(int m, logic [31:0] pc);
    return m_hit(m, pc) && (pht_m[m][m_idx(m, pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(int m, logic [31:0] pc);
    return m_hit(m, pc) ? tgt_m[m][pc_slot(pc)] : 32'd0;
  endfunction

  function automatic bit exp_misp();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));
  endfunction

  function automatic logic [31:0] exp_redirect();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic void m_update(int m, int idx, bit mp);
    if (upd_taken) pht_m[m][idx] = (pht_m[m][idx] < 3) ? pht_m[m][idx] + 1 : 3;
    else           pht_m[m][idx] = (pht_m[m][idx] > 0) ? pht_m[m][idx] - 1 : 0;
    if (upd_taken) begin
      bv_m[m][pc_slot(upd_pc)]  = 1;
      tag_m[m][pc_slot(upd_pc)] = pc_tag(upd_pc);
      tgt_m[m][pc_slot(upd_pc)] = upd_target;
    end
    ghr_m[m] = (ghr_m[m] * 2 + int'(upd_taken)) % 16;
    if (bcnt_m[m] < cnt_max(m)) bcnt_m[m]++;
    if (mp && mcnt_m[m] < cnt_max(m)) mcnt_m[m]++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    bit mp;
    @(posedge clk);
    if (rst) m_reset();
    else if (upd_valid) begin
      mp = exp_misp();
      m_update(0, int'(upd_idx_b), mp);
      m_update(1, int'(upd_idx_g), mp);
    end
    @(negedge clk);
  endtask

  task automatic set_upd(logic [31:0] pc, bit tk, logic [31:0] tgt, bit ptk, logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    upd_idx_b = 4'(m_idx(0, pc));
    upd_idx_g = 4'(m_idx(1, pc));
  endtask

  task automatic do_reset();
    rst = 1'b1; upd_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    if_pc = 32'h40;
    #2;
    checks++; if (b_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", b_hit); end
    checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b want 0", b_taken); end
    checks++; if (b_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %0h want 0", b_target); end
    checks++; if ({b_bcnt, b_mcnt} !== 8'h0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", {b_bcnt, b_mcnt}); end
    checks++; if ({g_hit, g_taken, g_bcnt, g_mcnt} !== 34'h0) begin errors++; $display("FAIL reset_g: got %0h want 0", {g_hit, g_taken, g_bcnt, g_mcnt}); end
    checks++; if (b_misp !== 1'b0) begin errors++; $display("FAIL reset_misp: got %0b want 0", b_misp); end
  endtask

  task automatic test_bimodal_train();
    if_pc = 32'h40;
    for (int k = 0; k < 2; k++) begin
      set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      #2;
      checks++; if (b_misp !== 1'b1) begin errors++; $display("FAIL train_misp%0d: got %0b want 1", k, b_misp); end
      checks++; if (b_redirect !== 32'h80) begin errors++; $display("FAIL train_redirect%0d: got %0h want 80", k, b_redirect); end
      checks++; if (b_hit !== (k == 1)) begin errors++; $display("FAIL train_nobypass%0d: got %0b want %0b", k, b_hit, k == 1); end
      tick();
    end
    upd_valid = 1'b0;
    #2;
    checks++; if ({b_hit, b_taken, b_target} !== {2'b11, 32'h80}) begin errors++; $display("FAIL train_lookup: got %0h want 3_00000080", {b_hit, b_taken, b_target}); end
    checks++; if (b_mcnt !== 4'd2) begin errors++; $display("FAIL train_mcnt: got %0d want 2", b_mcnt); end
    checks++; if (b_bcnt !== 4'd2) begin errors++; $display("FAIL train_bcnt: got %0d want 2", b_bcnt); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      #2;
      checks++; if (b_misp !== 1'b0) begin errors++; $display("FAIL sat_correct%0d: got %0b want 0", k, b_misp); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      set_upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
      #2;
      checks++; if ({b_misp, b_redirect} !== {1'b1, 32'h44}) begin errors++; $display("FAIL sat_nt_redirect%0d: got %0h want 1_00000044", k, {b_misp, b_redirect}); end
      checks++; if (b_taken !== 1'b1) begin errors++; $display("FAIL sat_still_taken%0d: got %0b want 1", k, b_taken); end
      tick();
    end
    upd_valid = 1'b0;
    #2;
    checks++; if ({b_hit, b_taken} !== 2'b10) begin errors++; $display("FAIL sat_after: got %0b want 10", {b_hit, b_taken}); end
    checks++; if ({b_bcnt, b_mcnt} !== {4'd7, 4'd4}) begin errors++; $display("FAIL sat_cnts: got %0h want 74", {b_bcnt, b_mcnt}); end
  endtask

  task automatic test_aliasing();
    set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);   tick();
    set_upd(32'h440, 1'b1, 32'h900, 1'b0, 32'h0); tick();
    upd_valid = 1'b0;
    if_pc = 32'h40; #1;
    checks++; if (b_hit !== 1'b0) begin errors++; $display("FAIL alias_old_miss: got %0b want 0", b_hit); end
    if_pc = 32'h440; #1;
    checks++; if ({b_hit, b_target, b_idx} !== {1'b1, 32'h900, 4'h0}) begin errors++; $display("FAIL alias_new_hit: got %0h want 1_00000900_0", {b_hit, b_target, b_idx}); end
    set_upd(32'h440, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    upd_valid = 1'b0; #2;
    checks++; if ({b_hit, b_target} !== {1'b1, 32'h900}) begin errors++; $display("FAIL alias_nt_keeps_btb: got %0h want 1_00000900", {b_hit, b_target}); end
  endtask

  task automatic test_gshare();
    bit outs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_upd(32'h104 + 32'(4 * k), outs[k], 32'h300, outs[k], 32'h300);
      tick();
    end
    upd_valid = 1'b0;
    if_pc = 32'h40; #2;
    checks++; if (g_idx !== 4'hD) begin errors++; $display("FAIL gshare_idx: got %0h want d", g_idx); end
    checks++; if (b_idx !== 4'h0) begin errors++; $display("FAIL bimodal_idx: got %0h want 0", b_idx); end
    set_upd(32'h40, 1'b1, 32'h84, 1'b1, 32'h80); #2;
    checks++; if ({g_misp, g_redirect} !== {1'b1, 32'h84}) begin errors++; $display("FAIL gshare_tgt_misp: got %0h want 1_00000084", {g_misp, g_redirect}); end
    upd_valid = 1'b0; #1;
    checks++; if ({b_misp, g_misp} !== 2'b00) begin errors++; $display("FAIL idle_misp: got %0b want 00", {b_misp, g_misp}); end
  endtask

  task automatic test_reset_mid();
    set_upd(32'h440, 1'b1, 32'h900, 1'b0, 32'h0); tick();
    rst = 1'b1;
    set_upd(32'h440, 1'b1, 32'h900, 1'b0, 32'h0); #2;
    checks++; if (b_misp !== 1'b1) begin errors++; $display("FAIL rstmid_misp_comb: got %0b want 1", b_misp); end
    tick();
    rst = 1'b0; upd_valid = 1'b0; if_pc = 32'h440; #2;
    checks++; if ({b_hit, b_bcnt, b_mcnt} !== 9'h0) begin errors++; $display("FAIL rstmid_b: got %0h want 0", {b_hit, b_bcnt, b_mcnt}); end
    checks++; if ({g_hit, g_idx, g_bcnt, g_mcnt} !== 37'h0) begin errors++; $display("FAIL rstmid_g: got %0h want 0", {g_hit, g_idx, g_bcnt, g_mcnt}); end
  endtask

  task automatic test_cnt_sat();
    for (int k = 0; k < 20; k++) begin
      set_upd(32'h200, 1'b1, 32'h80, 1'b0, 32'h0);
      tick();
    end
    upd_valid = 1'b0; #2;
    checks++; if ({b_bcnt, b_mcnt} !== 8'hFF) begin errors++; $display("FAIL cnt_sat_b: got %0h want ff", {b_bcnt, b_mcnt}); end
    checks++; if ({g_bcnt, g_mcnt} !== {16'd20, 16'd20}) begin errors++; $display("FAIL cnt_g: got %0d/%0d want 20/20", g_bcnt, g_mcnt); end
  endtask

  task automatic test_random();
    logic [46:0] exp_b, act_b;
    logic [70:0] exp_g, act_g;
    logic [31:0] pc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if_pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      pc    = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
      set_upd(pc, 1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 7)) * 4,
              ($urandom_range(0, 1) == 1) ? m_taken(0, pc) : 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? m_target(0, pc) : 32'h2000 + 32'($urandom_range(0, 7)) * 4);
      upd_valid = ($urandom_range(0, 3) != 0);
      #2;
      exp_b = {m_hit(0, if_pc), m_taken(0, if_pc), m_target(0, if_pc), 4'(m_idx(0, if_pc)),
               exp_misp(), 4'(bcnt_m[0]), 4'(mcnt_m[0])};
      act_b = {b_hit, b_taken, b_target, b_idx, b_misp, b_bcnt, b_mcnt};
      exp_g = {m_hit(1, if_pc), m_taken(1, if_pc), m_target(1, if_pc), 4'(m_idx(1, if_pc)),
               exp_misp(), 16'(bcnt_m[1]), 16'(mcnt_m[1])};
      act_g = {g_hit, g_taken, g_target, g_idx, g_misp, g_bcnt, g_mcnt};
      checks++; if (act_b !== exp_b) begin errors++; $display("FAIL rand_b cycle %0d: got %0h want %0h", n, act_b, exp_b); end
      checks++; if (act_g !== exp_g) begin errors++; $display("FAIL rand_g cycle %0d: got %0h want %0h", n, act_g, exp_g); end
      if (upd_valid) begin
        checks++; if ({b_redirect, g_redirect} !== {exp_redirect(), exp_redirect()}) begin errors++; $display("FAIL rand_redirect cycle %0d: got %0h/%0h want %0h", n, b_redirect, g_redirect, exp_redirect()); end
      end
      tick();
    end
    rst = 1'b0; upd_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_idx_b = 4'h0; upd_idx_g = 4'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    m_reset();
    test_reset();
    test_bimodal_train();
    test_saturation();
    test_aliasing();
    test_gshare();
    test_reset_mid();
    test_cnt_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
